// File: rtl/fft16_pkg.sv
// fft16_pkg: shared types and helpers for the FFT16 datapath.
//   sample_t   : complex sample, real in [31:16], imag in [15:0]
//   re_of/im_of: component slices of a sample
//   bitrev     : reverse the low 'bits' bits of an index
//   state_e    : unloader FSM states
package fft16_pkg;

  localparam int DATA_WIDTH_DEF        = 16;
  localparam int DOUBLE_DATA_WIDTH_DEF = 2 * DATA_WIDTH_DEF;
  localparam int DEPTH_DEF             = 32;
  localparam int IDX_MAX_W             = 16;

  typedef logic signed [DOUBLE_DATA_WIDTH_DEF-1:0] sample_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic logic signed [DATA_WIDTH_DEF-1:0] re_of(input sample_t s);
    return s[DOUBLE_DATA_WIDTH_DEF-1:DATA_WIDTH_DEF];
  endfunction

  function automatic logic signed [DATA_WIDTH_DEF-1:0] im_of(input sample_t s);
    return s[DATA_WIDTH_DEF-1:0];
  endfunction

  // Shifting the input LSB-first into the result leaves the low 'bits'
  // bits reversed and everything above them zero.
  function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] v,
                                                  input int unsigned bits);
    logic [IDX_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IDX_MAX_W; i++) begin
      if (i < bits) begin
        r = {r[IDX_MAX_W-2:0], v[i]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_par_ser.sv
// fft16_par_ser: captures a whole frame of DEPTH complex samples in one cycle
// and streams it out two samples per beat under a valid/ready handshake.
// Build option: define FFT16_PAR_SER_BITREV_EN to read slot s from frame
// index bitrev(s), undoing the FFT core's bit-reversed output order.
// Ports:
//   clk, i_rst_n          clock, async active-low reset
//   i_load, i_data        frame strobe and parallel frame (accepted with o_ready)
//   o_ready               frame can be accepted this cycle (combinational)
//   o_valid, i_ready      beat handshake
//   o1_data, o2_data      even / odd slot samples of the beat
//   o_idx                 slot number of o1_data (0,2,4,...)
//   o_last                final beat of the frame
//   o_drop                one-cycle pulse after a frame offered while busy
import fft16_pkg::*;

module fft16_par_ser #(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int DEPTH             = DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                i_rst_n,
  input  logic                                i_load,
  input  logic signed [DOUBLE_DATA_WIDTH-1:0] i_data [DEPTH-1:0],
  output logic                                o_ready,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic signed [DOUBLE_DATA_WIDTH-1:0] o1_data,
  output logic signed [DOUBLE_DATA_WIDTH-1:0] o2_data,
  output logic        [$clog2(DEPTH)-1:0]     o_idx,
  output logic                                o_last,
  output logic                                o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = AW - 1;
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH / 2 - 1);

  state_e                               state_q;
  logic signed [DOUBLE_DATA_WIDTH-1:0]  frame_q [DEPTH-1:0];
  logic        [KW-1:0]                 k_q;
  logic        [KW-1:0]                 k_d;
  logic signed [DOUBLE_DATA_WIDTH-1:0]  o1_q;
  logic signed [DOUBLE_DATA_WIDTH-1:0]  o2_q;
  logic        [AW-1:0]                 idx_q;
  logic                                 last_q;
  logic                                 valid_q;
  logic                                 drop_q;
  logic                                 ready_s;
  logic                                 load_s;
  logic                                 adv_s;
  logic                                 fin_s;

  // Frame storage index for a natural output slot.
  function automatic logic [AW-1:0] rd_idx(input logic [AW-1:0] s);
`ifdef FFT16_PAR_SER_BITREV_EN
    return AW'(bitrev(IDX_MAX_W'(s), AW));
`else
    return s;
`endif
  endfunction

  // A new frame may enter in IDLE, or on the very cycle the last beat leaves.
  assign ready_s = (state_q == ST_IDLE) ||
                   ((state_q == ST_SEND) && valid_q && i_ready && last_q);
  assign load_s  = i_load && ready_s;
  assign adv_s   = valid_q && i_ready && !last_q;
  assign fin_s   = valid_q && i_ready && last_q && !i_load;
  assign k_d     = k_q + KW'(1);

  // Unloader FSM: frame capture, beat counter and registered beat outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        frame_q[i] <= '0;
      end
      k_q     <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= i_load && !ready_s;
      if (load_s) begin
        frame_q <= i_data;
        state_q <= ST_SEND;
        valid_q <= 1'b1;
        k_q     <= '0;
        idx_q   <= '0;
        last_q  <= 1'b0;
        o1_q    <= i_data[rd_idx(AW'(0))];
        o2_q    <= i_data[rd_idx(AW'(1))];
      end else if (adv_s) begin
        k_q     <= k_d;
        idx_q   <= {k_d, 1'b0};
        last_q  <= (k_d == K_LAST);
        o1_q    <= frame_q[rd_idx({k_d, 1'b0})];
        o2_q    <= frame_q[rd_idx({k_d, 1'b1})];
      end else if (fin_s) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign o_ready = ready_s;
  assign o_valid = valid_q;
  assign o1_data = o1_q;
  assign o2_data = o2_q;
  assign o_idx   = idx_q;
  assign o_last  = last_q;
  assign o_drop  = drop_q;

endmodule
